// File: rtl/drive_pkg.sv
// drive_pkg: shared encodings and defaults for the drive sequencer.
// State codes are visible on state_o, so their values are fixed.
package drive_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FOLLOW  = 3'd1,
        ST_STOP    = 3'd2,
        ST_REVERSE = 3'd3,
        ST_TURN    = 3'd4
    } state_e;

    // Width of the phase timer, the measurement watchdog and the PWM counter
    localparam int TIMER_W = 32;

    localparam int DEF_DIST_W       = 9;
    localparam int DEF_STOP_DIST    = 15;
    localparam int DEF_CLEAR_DIST   = 20;
    localparam int DEF_HOLD_CYCLES  = 5_000_000;
    localparam int DEF_REV_CYCLES   = 25_000_000;
    localparam int DEF_TURN_CYCLES  = 12_500_000;
    localparam int DEF_MEAS_TIMEOUT = 3_000_000;

    // Timer load value for a phase lasting `cycles` clock cycles (cycles >= 1)
    function automatic logic [TIMER_W-1:0] phase_load(input int cycles);
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: free-running 0..PERIOD-1 counter; pwm_o high while count < DUTY.
// DUTY >= PERIOD yields a constant-high output.
module pwm_gen
    import drive_pkg::*;
#(
    parameter int PERIOD = 1000,
    parameter int DUTY   = 700
) (
    input  logic clk,
    input  logic rst_n,
    output logic pwm_o
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    // Next count: wrap to zero at the end of the period
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q >= TIMER_W'(PERIOD - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TIMER_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pwm_o = (cnt_q < TIMER_W'(DUTY));

endmodule

// File: rtl/drive_sequencer.sv
// drive_sequencer: line-follow / obstacle-escape motion controller.
// Optional feature macro SPEED_PWM_EN: motor enables are gated by a speed PWM.
// Motor and direction pins are registered from the state held before the edge;
// abort forces them low on the same edge it returns the FSM to IDLE.
module drive_sequencer
    import drive_pkg::*;
#(
    parameter int DIST_W       = DEF_DIST_W,
    parameter int STOP_DIST    = DEF_STOP_DIST,
    parameter int CLEAR_DIST   = DEF_CLEAR_DIST,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int REV_CYCLES   = DEF_REV_CYCLES,
    parameter int TURN_CYCLES  = DEF_TURN_CYCLES,
    parameter int MEAS_TIMEOUT = DEF_MEAS_TIMEOUT
`ifdef SPEED_PWM_EN
    ,
    parameter int PWM_PERIOD   = 1000,
    parameter int PWM_DUTY     = 700
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DIST_W-1:0] distancia,
    input  logic              dist_valid,
    output logic              meas_req,
    input  logic              line_l,
    input  logic              line_r,
    output logic              m_izquierdo,
    output logic              m_derecho,
    output logic              dir_izq,
    output logic              dir_der,
    output logic [2:0]        state_o,
    output logic              busy
);

    localparam logic [DIST_W-1:0] STOP_T  = DIST_W'(STOP_DIST);
    localparam logic [DIST_W-1:0] CLEAR_T = DIST_W'(CLEAR_DIST);

    state_e             state_q,    state_d;
    logic [TIMER_W-1:0] timer_q,    timer_d;
    logic [TIMER_W-1:0] mto_q,      mto_d;
    logic [DIST_W-1:0]  dist_q,     dist_d;
    logic               meas_req_q, meas_req_d;
    logic               busy_q,     busy_d;
    logic               m_izq_q,    m_izq_d;
    logic               m_der_q,    m_der_d;
    logic               dir_izq_q,  dir_izq_d;
    logic               dir_der_q,  dir_der_d;
    logic               motor_en_s;
    logic               obstacle_s;
    logic               clear_s;

`ifdef SPEED_PWM_EN
    logic pwm_s;

    pwm_gen #(
        .PERIOD (PWM_PERIOD),
        .DUTY   (PWM_DUTY)
    ) u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm_o (pwm_s)
    );

    assign motor_en_s = pwm_s;
`else
    assign motor_en_s = 1'b1;
`endif

    assign obstacle_s = (dist_q < STOP_T);
    assign clear_s    = (dist_q >= CLEAR_T);

    // Next state and phase timer; decisions use dist_q as registered before the edge
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (abort) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timer_d = '0;
                    if (start) begin
                        state_d = ST_FOLLOW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FOLLOW: begin
                    if (obstacle_s) begin
                        state_d = ST_STOP;
                        timer_d = phase_load(HOLD_CYCLES);
                    end else begin
                        timer_d = '0;
                    end
                end
                ST_STOP: begin
                    if (timer_q == '0) begin
                        if (clear_s) begin
                            state_d = ST_FOLLOW;
                            timer_d = '0;
                        end else begin
                            state_d = ST_REVERSE;
                            timer_d = phase_load(REV_CYCLES);
                        end
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                ST_REVERSE: begin
                    if (timer_q == '0) begin
                        state_d = ST_TURN;
                        timer_d = phase_load(TURN_CYCLES);
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                ST_TURN: begin
                    if (timer_q == '0) begin
                        state_d = ST_STOP;
                        timer_d = phase_load(HOLD_CYCLES);
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Measurement engine: request until a strobe, drop for one cycle, re-request;
    // a watchdog expiry forces dist to 0 so the robot treats silence as an obstacle
    always_comb begin
        dist_d     = dist_q;
        mto_d      = mto_q;
        meas_req_d = 1'b0;
        if (abort || (state_q == ST_IDLE)) begin
            mto_d      = '0;
            meas_req_d = 1'b0;
        end else if (dist_valid) begin
            dist_d     = distancia;
            mto_d      = '0;
            meas_req_d = 1'b0;
        end else if (mto_q == TIMER_W'(MEAS_TIMEOUT - 1)) begin
            dist_d     = '0;
            mto_d      = '0;
            meas_req_d = 1'b0;
        end else begin
            mto_d      = mto_q + TIMER_W'(1);
            meas_req_d = 1'b1;
        end
    end

    // Motor pins from the current state, gated by the speed enable
    always_comb begin
        m_izq_d   = 1'b0;
        m_der_d   = 1'b0;
        dir_izq_d = 1'b0;
        dir_der_d = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        if (abort) begin
            m_izq_d = 1'b0;
            m_der_d = 1'b0;
        end else begin
            case (state_q)
                ST_FOLLOW: begin
                    m_izq_d = line_l & motor_en_s;
                    m_der_d = line_r & motor_en_s;
                end
                ST_REVERSE: begin
                    m_izq_d   = motor_en_s;
                    m_der_d   = motor_en_s;
                    dir_izq_d = 1'b1;
                    dir_der_d = 1'b1;
                end
                ST_TURN: begin
                    m_izq_d   = motor_en_s;
                    m_der_d   = motor_en_s;
                    dir_der_d = 1'b1;
                end
                default: begin
                    m_izq_d = 1'b0;
                    m_der_d = 1'b0;
                end
            endcase
        end
    end

    // State, timers, distance and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            mto_q      <= '0;
            dist_q     <= '0;
            meas_req_q <= 1'b0;
            busy_q     <= 1'b0;
            m_izq_q    <= 1'b0;
            m_der_q    <= 1'b0;
            dir_izq_q  <= 1'b0;
            dir_der_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            mto_q      <= mto_d;
            dist_q     <= dist_d;
            meas_req_q <= meas_req_d;
            busy_q     <= busy_d;
            m_izq_q    <= m_izq_d;
            m_der_q    <= m_der_d;
            dir_izq_q  <= dir_izq_d;
            dir_der_q  <= dir_der_d;
        end
    end

    assign state_o     = state_q;
    assign busy        = busy_q;
    assign meas_req    = meas_req_q;
    assign m_izquierdo = m_izq_q;
    assign m_derecho   = m_der_q;
    assign dir_izq     = dir_izq_q;
    assign dir_der     = dir_der_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// tb_drive_sequencer: randomized scoreboard bench for drive_sequencer with
// shortened phase durations. Honours SPEED_PWM_EN (PERIOD 10, DUTY 7).
module tb_drive_sequencer;

    localparam int DW    = 9;
    localparam int STOPD = 15;
    localparam int CLRD  = 20;
    localparam int HOLD  = 4;
    localparam int REV   = 6;
    localparam int TURN  = 3;
    localparam int MTO   = 30;
`ifdef SPEED_PWM_EN
    localparam int PP    = 10;
    localparam int PD    = 7;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          dist_valid = 1'b0;
    logic [DW-1:0] distancia = '0;
    logic          line_l = 1'b0;
    logic          line_r = 1'b0;
    logic          meas_req, m_izquierdo, m_derecho, dir_izq, dir_der, busy;
    logic [2:0]    state_o;

    always #5 clk = ~clk;

    drive_sequencer #(
        .DIST_W       (DW),
        .STOP_DIST    (STOPD),
        .CLEAR_DIST   (CLRD),
        .HOLD_CYCLES  (HOLD),
        .REV_CYCLES   (REV),
        .TURN_CYCLES  (TURN),
        .MEAS_TIMEOUT (MTO)
`ifdef SPEED_PWM_EN
        ,
        .PWM_PERIOD   (PP),
        .PWM_DUTY     (PD)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .distancia   (distancia),
        .dist_valid  (dist_valid),
        .meas_req    (meas_req),
        .line_l      (line_l),
        .line_r      (line_r),
        .m_izquierdo (m_izquierdo),
        .m_derecho   (m_derecho),
        .dir_izq     (dir_izq),
        .dir_der     (dir_der),
        .state_o     (state_o),
        .busy        (busy)
    );

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q[$];

    // Reference model: mode 0..4, cycles spent in the timed mode, last distance,
    // cycles since the request (re)started, PWM position
    int m_mode, m_elapsed, m_dist, m_wait, m_pwm;
    bit m_req, m_mi, m_md, m_di, m_dd;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endfunction

    function automatic logic [8:0] dut_vec();
        return {state_o, busy, meas_req, m_izquierdo, m_derecho, dir_izq, dir_der};
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_elapsed = 0; m_dist = 0; m_wait = 0; m_pwm = 0;
        m_req = 0; m_mi = 0; m_md = 0; m_di = 0; m_dd = 0;
    endfunction

    // One clock edge of the intended behaviour; returns the outputs after it
    function automatic logic [8:0] model_step(bit s, bit a, bit dv, int d, bit ll, bit lr);
        int prev;
        bit en;
        prev = m_mode;
        en = 1'b1;
`ifdef SPEED_PWM_EN
        en = (m_pwm < PD);
        m_pwm = (m_pwm + 1) % PP;
`endif
        m_mi = 0; m_md = 0; m_di = 0; m_dd = 0;
        if (!a) begin
            if (prev == 1) begin m_mi = ll & en; m_md = lr & en; end
            else if (prev == 3) begin m_mi = en; m_md = en; m_di = 1; m_dd = 1; end
            else if (prev == 4) begin m_mi = en; m_md = en; m_dd = 1; end
        end
        if (a) begin
            m_mode = 0; m_elapsed = 0;
        end else begin
            case (prev)
                0: if (s) m_mode = 1;
                1: if (m_dist < STOPD) begin m_mode = 2; m_elapsed = 0; end
                2: begin
                    m_elapsed++;
                    if (m_elapsed == HOLD) begin
                        m_mode = (m_dist >= CLRD) ? 1 : 3;
                        m_elapsed = 0;
                    end
                end
                3: begin
                    m_elapsed++;
                    if (m_elapsed == REV) begin m_mode = 4; m_elapsed = 0; end
                end
                4: begin
                    m_elapsed++;
                    if (m_elapsed == TURN) begin m_mode = 2; m_elapsed = 0; end
                end
                default: m_mode = 0;
            endcase
        end
        if (a || prev == 0) begin m_req = 0; m_wait = 0; end
        else if (dv) begin m_dist = d; m_req = 0; m_wait = 0; end
        else if (m_wait + 1 == MTO) begin m_dist = 0; m_req = 0; m_wait = 0; end
        else begin m_wait++; m_req = 1; end
        return {3'(m_mode), (m_mode != 0), m_req, m_mi, m_md, m_di, m_dd};
    endfunction

    // Drive inputs for the next edge (called 2 time units after an edge),
    // record the expected response, then step past that edge
    task automatic cycle(bit s, bit a, bit dv, int d);
        logic [DW-1:0] dv_bits;
        dv_bits    = d[DW-1:0];
        start      = s;
        abort      = a;
        dist_valid = dv;
        distancia  = dv_bits;
        line_l     = 1'($urandom % 2);
        line_r     = 1'($urandom % 2);
        exp_q.push_back(model_step(s, a, dv, int'(dv_bits), line_l, line_r));
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset between edges; outputs must clear at once
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; dist_valid = 1'b0;
        #1;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_meas_req", 32'(meas_req), 32'd0);
        check("rst_motors", 32'({m_izquierdo, m_derecho}), 32'd0);
        check("rst_dirs", 32'({dir_izq, dir_der}), 32'd0);
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Run obstacle strobes until the model enters `target`, bounded
    task automatic wait_mode(int target, int bound);
        for (int i = 0; i < bound && m_mode != target; i++) begin
            cycle(1'b0, 1'b0, (i % 3 == 0), 10);
        end
        check("reach_mode", 32'(state_o), 32'(target));
    endtask

    // Monitor: compare DUT outputs against the scoreboard after every edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                check("cycle_outputs", 32'(dut_vec()), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        model_reset();
        do_reset();

        // start, then a far reading; reset distance 0 first forces one STOP
        cycle(1'b1, 1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 1'b1, 100);
        repeat (12) cycle(1'b0, 1'b0, 1'b0, 0);
        check("follow_far", 32'(state_o), 32'd1);

        // obstacle: STOP, REVERSE, TURN, back to STOP
        for (int i = 0; i < HOLD + REV + TURN + 6; i++) begin
            cycle(1'b0, 1'b0, (i % 3 == 0), 10);
        end

        // hysteresis: 18 after STOP still reverses, 20 resumes following
        wait_mode(2, 40);
        cycle(1'b0, 1'b0, 1'b1, 18);
        repeat (HOLD - 1) cycle(1'b0, 1'b0, 1'b0, 0);
        check("hyst_rev", 32'(state_o), 32'd3);
        wait_mode(2, 40);
        cycle(1'b0, 1'b0, 1'b1, 20);
        repeat (HOLD - 1) cycle(1'b0, 1'b0, 1'b0, 0);
        check("hyst_clear", 32'(state_o), 32'd1);

        // silence from the ranging block: watchdog forces an obstacle
        repeat (MTO) cycle(1'b0, 1'b0, 1'b0, 0);
        check("timeout_stop", 32'(state_o), 32'd2);

        // abort beats start during REVERSE
        wait_mode(3, 40);
        cycle(1'b1, 1'b1, 1'b0, 0);
        check("abort_idle", 32'(state_o), 32'd0);
        check("abort_motors", 32'({m_izquierdo, m_derecho, dir_izq, dir_der}), 32'd0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            int d;
            d = ($urandom % 3 == 0) ? int'($urandom % 512) : int'($urandom_range(30, 5));
            cycle(($urandom % 20) == 0, ($urandom % 80) == 0, ($urandom % 6) == 0, d);
        end

        // reset in the middle of TURN
        cycle(1'b1, 1'b0, 1'b0, 0);
        wait_mode(4, 60);
        do_reset();
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 0);

        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
